// File: rtl/reg_write_queue_if.sv
// Write-request channel into the register-file write queue.
// The requester drives the master side; the queue is the slave.
interface reg_write_queue_if #(
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_reg;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_reg,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_reg,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/reg_write_queue.sv
// In-order write-back queue feeding the 16-entry register file through a registered one-hot wordline.
// Define REG_WRITE_BYPASS_EN to build the youngest-match lookup; otherwise lookup_hit/lookup_data read 0.
module reg_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_write_queue_if.slave         wr,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     WriteEnable,
    output logic [15:0]              Wordline,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [3:0]               lookup_reg,
    output logic                     lookup_hit,
    output logic [DATA_W-1:0]        lookup_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state, state_next;
    logic [3:0]          reg_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic                full;
    logic                accept;
    logic                do_enq;
    logic                do_pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign wr.wr_ready = !full;
    assign accept      = wr.wr_valid && !full && !flush;
    // R0 is hardwired zero: the handshake completes but nothing is stored.
    assign do_enq      = accept && (wr.wr_reg != 4'd0);
    assign do_pop      = (state == ACTIVE) && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_enq) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (do_pop && (count == CNT_W'(1)) && !do_enq) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            if (do_enq && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            reg_mem[tail]  <= wr.wr_reg;
            data_mem[tail] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WriteEnable <= 1'b0;
            Wordline    <= '0;
            WriteData   <= '0;
        end else if (do_pop) begin
            WriteEnable <= 1'b1;
            Wordline    <= 16'd1 << reg_mem[head];
            WriteData   <= data_mem[head];
        end else begin
            WriteEnable <= 1'b0;
            Wordline    <= '0;
        end
    end

`ifdef REG_WRITE_BYPASS_EN
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        if (lookup_reg != 4'd0) begin
            if (WriteEnable && Wordline[lookup_reg]) begin
                lookup_hit  = 1'b1;
                lookup_data = WriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && (reg_mem[idx] == lookup_reg)) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data_mem[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^lookup_reg;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed self-checking bench for reg_write_queue; lookup expectations follow REG_WRITE_BYPASS_EN.
module tb_reg_write_queue;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        WriteEnable;
    logic [15:0] Wordline;
    logic [15:0] WriteData;
    logic [3:0]  lookup_reg;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    logic [2:0]  count;

    int checks;
    int errors;

    reg_write_queue_if #(.DATA_W(16)) wr_if ();

    reg_write_queue #(
        .DEPTH  (4),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr_if.slave),
        .stall       (stall),
        .flush       (flush),
        .WriteEnable (WriteEnable),
        .Wordline    (Wordline),
        .WriteData   (WriteData),
        .lookup_reg  (lookup_reg),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] rid, input logic [15:0] data);
        wr_if.wr_valid = valid;
        wr_if.wr_reg   = rid;
        wr_if.wr_data  = data;
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // With the bypass built, a hit returns data; otherwise both read zero.
    task automatic checkLookup(input string tag, input logic [3:0] rid, input logic hit, input logic [15:0] data);
        lookup_reg = rid;
        #1;
`ifdef REG_WRITE_BYPASS_EN
        checkOutput({tag, "_hit"}, 32'(lookup_hit), 32'(hit));
        checkOutput({tag, "_data"}, 32'(lookup_data), 32'(hit ? data : 16'h0));
`else
        checkOutput({tag, "_hit"}, 32'(lookup_hit), 32'h0);
        checkOutput({tag, "_data"}, 32'(lookup_data), 32'h0);
`endif
    endtask

    initial begin
        logic [15:0] expWl;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        lookup_reg = 4'd0;
        applyStimulus(1'b0, 4'd0, 16'h0);
        #3;
        checkOutput("rst_ready", 32'(wr_if.wr_ready), 32'h1);
        checkOutput("rst_we", 32'(WriteEnable), 32'h0);
        checkOutput("rst_wl", 32'(Wordline), 32'h0);
        checkOutput("rst_wd", 32'(WriteData), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkLookup("rst_lk", 4'd5, 1'b0, 16'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] single write");
        applyStimulus(1'b1, 4'd5, 16'hABCD);
        tick();
        checkOutput("sw_count1", 32'(count), 32'h1);
        checkOutput("sw_we_e1", 32'(WriteEnable), 32'h0);
        applyStimulus(1'b0, 4'd0, 16'h0);
        tick();
        checkOutput("sw_we_e2", 32'(WriteEnable), 32'h1);
        checkOutput("sw_wl_e2", 32'(Wordline), 32'h0020);
        checkOutput("sw_wd_e2", 32'(WriteData), 32'hABCD);
        checkOutput("sw_count2", 32'(count), 32'h0);
        checkLookup("sw_lk_out", 4'd5, 1'b1, 16'hABCD);
        tick();
        checkOutput("sw_we_e3", 32'(WriteEnable), 32'h0);
        checkOutput("sw_wl_e3", 32'(Wordline), 32'h0);
        checkOutput("sw_wd_hold", 32'(WriteData), 32'hABCD);

        $display("[TB] R0 discard");
        applyStimulus(1'b1, 4'd0, 16'h1234);
        #1;
        checkOutput("r0_ready", 32'(wr_if.wr_ready), 32'h1);
        tick();
        checkOutput("r0_count", 32'(count), 32'h0);
        applyStimulus(1'b0, 4'd0, 16'h0);
        tick();
        checkOutput("r0_we", 32'(WriteEnable), 32'h0);
        tick();
        checkOutput("r0_we2", 32'(WriteEnable), 32'h0);

        $display("[TB] fill under stall");
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 4'(i), 16'h1000 + 16'(i));
            tick();
            checkOutput("fill_we", 32'(WriteEnable), 32'h0);
        end
        checkOutput("fill_count", 32'(count), 32'h4);
        checkOutput("fill_ready", 32'(wr_if.wr_ready), 32'h0);
        applyStimulus(1'b1, 4'd6, 16'h6666);
        tick();
        checkOutput("fill_5th", 32'(count), 32'h4);
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkLookup("fill_lk3", 4'd3, 1'b1, 16'h1003);
        checkLookup("fill_lk6", 4'd6, 1'b0, 16'h0);
        stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expWl = 16'd1 << i;
            checkOutput("drain_we", 32'(WriteEnable), 32'h1);
            checkOutput("drain_wl", 32'(Wordline), 32'(expWl));
            checkOutput("drain_wd", 32'(WriteData), 32'h1000 + 32'(i));
        end
        checkOutput("drain_count", 32'(count), 32'h0);
        tick();
        checkOutput("drain_we_end", 32'(WriteEnable), 32'h0);

        $display("[TB] enqueue and pop together");
        stall = 1'b1;
        applyStimulus(1'b1, 4'd10, 16'h0A0A);
        tick();
        stall = 1'b0;
        applyStimulus(1'b1, 4'd11, 16'h0B0B);
        tick();
        checkOutput("ep_count", 32'(count), 32'h1);
        checkOutput("ep_wl", 32'(Wordline), 32'h0400);
        applyStimulus(1'b0, 4'd0, 16'h0);
        tick();
        checkOutput("ep_wl2", 32'(Wordline), 32'h0800);
        checkOutput("ep_wd2", 32'(WriteData), 32'h0B0B);
        checkOutput("ep_count2", 32'(count), 32'h0);
        tick();

        $display("[TB] youngest match");
        stall = 1'b1;
        applyStimulus(1'b1, 4'd7, 16'h0001);
        tick();
        applyStimulus(1'b1, 4'd7, 16'h0002);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkLookup("ym_r7", 4'd7, 1'b1, 16'h0002);
        checkLookup("ym_r0", 4'd0, 1'b0, 16'h0);
        checkLookup("ym_r9", 4'd9, 1'b0, 16'h0);

        $display("[TB] flush with request");
        applyStimulus(1'b1, 4'd8, 16'h0008);
        tick();
        checkOutput("fl_count3", 32'(count), 32'h3);
        flush = 1'b1;
        stall = 1'b0;
        applyStimulus(1'b1, 4'd9, 16'h0009);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkOutput("fl_count", 32'(count), 32'h0);
        checkOutput("fl_we", 32'(WriteEnable), 32'h0);
        checkLookup("fl_lk7", 4'd7, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("fl_no_commit", 32'(WriteEnable), 32'h0);
        end

        $display("[TB] queue entry younger than output stage");
        applyStimulus(1'b1, 4'd3, 16'hAAAA);
        tick();
        applyStimulus(1'b1, 4'd3, 16'hBBBB);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkOutput("yo_wd", 32'(WriteData), 32'hAAAA);
        checkLookup("yo_both", 4'd3, 1'b1, 16'hBBBB);
        tick();
        checkLookup("yo_out", 4'd3, 1'b1, 16'hBBBB);
        tick();
        checkLookup("yo_none", 4'd3, 1'b0, 16'h0);

        $display("[TB] async reset mid-drain");
        applyStimulus(1'b1, 4'd12, 16'h5A5A);
        tick();
        applyStimulus(1'b1, 4'd13, 16'hC3C3);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkOutput("ar_we_pre", 32'(WriteEnable), 32'h1);
        checkOutput("ar_count_pre", 32'(count), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar_we", 32'(WriteEnable), 32'h0);
        checkOutput("ar_wl", 32'(Wordline), 32'h0);
        checkOutput("ar_wd", 32'(WriteData), 32'h0);
        checkOutput("ar_count", 32'(count), 32'h0);
        checkOutput("ar_ready", 32'(wr_if.wr_ready), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("ar_no_commit", 32'(WriteEnable), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

- Write side of the 16-entry register file. The read port decodes a 4-bit register ID into a one-hot wordline; this block is the matching writer.
- Accepts write-back requests through a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register file as a registered one-hot write wordline plus data.
- Offers a youngest-match lookup, so the read path can see pending writes that the register file does not hold yet.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, 2..8)
- DATA_W, 16, register data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  queue can accept; equals !full
- wr_reg  in  4  destination register ID
- wr_data  in  DATA_W  write data
- stall  in  1  register file cannot take a write this cycle
- flush  in  1  synchronous discard of all pending writes
- WriteEnable  out  1  registered; register file writes at the next edge when high
- Wordline  out  16  registered one-hot of the committing register ID; all-zero when WriteEnable is low
- WriteData  out  DATA_W  registered commit data
- lookup_reg  in  4  register ID to search for
- lookup_hit  out  1  combinational; a pending write to lookup_reg exists
- lookup_data  out  DATA_W  combinational; data of the youngest matching pending write, 0 when there is no hit
- count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- Enqueue: on an edge with wr_valid && wr_ready && !flush, store {wr_reg, wr_data} at the tail.
  - When wr_reg == 0, the handshake completes but nothing is enqueued. R0 is hardwired zero.
- Drain, on each edge when !stall && !flush:
  - If the queue is non-empty, pop the head into the output stage: WriteEnable=1, Wordline=1<<reg, WriteData=data.
  - Otherwise set WriteEnable=0 and Wordline=0; WriteData holds its value.
- stall high: no pop; WriteEnable=0 and Wordline=0 at that edge; WriteData holds.
- Enqueue and pop in the same edge: both happen; count is unchanged.
- wr_ready is !full and does not depend on a same-cycle pop. When full, a pop frees a slot for the next cycle only.
- flush: at the edge, empty the queue (count=0), clear WriteEnable and Wordline, and drop any simultaneous request. flush has priority over enqueue and pop.
- Lookup covers queue entries and the output stage while WriteEnable=1. The youngest match wins; queue entries are younger than the output stage. lookup_reg=0 never hits.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Control flow is a two-state drain machine:
  - IDLE (queue empty) goes to ACTIVE when an entry is enqueued.
  - ACTIVE returns to IDLE when a pop empties the queue with no simultaneous enqueue, or on flush.

## Timing
- Reset values: WriteEnable=0, Wordline=0, WriteData=0, count=0, state IDLE.
- While empty, wr_ready=1, lookup_hit=0 and lookup_data=0; this includes the time rst is held.
- Reset mid-operation discards all pending and in-flight writes.
- Latency, empty queue with no stall: a request accepted at edge N drives WriteEnable=1 after edge N+1, and the register file commits at edge N+2.
- Throughput: one commit per cycle in steady state.
- lookup_hit and lookup_data are combinational from lookup_reg and state, with no added latency.

## Configuration
- REG_WRITE_BYPASS_EN defined: the lookup logic is built as described above.
- REG_WRITE_BYPASS_EN undefined: lookup_hit is tied to 0 and lookup_data to 0; the ports remain.

## Test plan
- Reset then single write: wr_reg=5, wr_data=16'hABCD accepted at edge 1 -> after edge 2, WriteEnable=1, Wordline=16'h0020, WriteData=16'hABCD; after edge 3, WriteEnable=0.
- R0 discard: write wr_reg=0, wr_data=16'h1234 -> wr_ready handshake completes, count stays 0, WriteEnable never rises.
- Fill under stall: stall=1, write regs 1,2,3,4 -> count=4 and wr_ready=0. A 5th request is not accepted.
  - Release stall -> Wordlines 0x0002, 0x0004, 0x0008, 0x0010 appear on four consecutive cycles, in order.
- Youngest-match lookup (macro defined): stall=1, write R7=16'h0001 then R7=16'h0002, lookup_reg=7 -> lookup_hit=1, lookup_data=16'h0002. With lookup_reg=0 -> lookup_hit=0.
- Flush with simultaneous request: 3 entries queued, flush=1 together with wr_valid=1 for R9 -> after the edge, count=0, WriteEnable=0, no R9 commit afterwards.
- Asynchronous reset mid-drain: assert rst between edges while WriteEnable=1 -> WriteEnable, Wordline, WriteData and count go to 0 immediately, before the next edge.
